riscv_mem_arbiter: RTL and testbench

Shares the single unified instruction/data memory of the multicycle RISC-V core between two requesters: instruction fetch (IF) and data load/store (DM). It sequences each access through a fixed-latency memory and uses 2-way round-robin arbitration. Responses return on per-requester valid strobes. It sits between the control unit/datapath and the memory model.

---
 rtl/riscv_mem_pkg.sv | 20 ++
 rtl/riscv_rr_arb2.sv | 24 ++
 rtl/riscv_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified-memory arbiter of the multicycle core.
package riscv_mem_pkg;

  // Requester identity; OWN_DM is the post-reset "last owner" so IF wins the first tie.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int MEM_LATENCY_DEF = 2;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Combinational 2-way round-robin picker: the requester that did not own the
// memory last wins a tie; a lone requester always wins.
module riscv_rr_arb2
  import riscv_mem_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  // Pick the winner from the current requests and the previous owner.
  always_comb begin
    valid  = if_req | dm_req;
    winner = OWN_IF;
    if (if_req && dm_req) begin
      winner = ~last_owner;
    end else if (dm_req) begin
      winner = OWN_DM;
    end
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the unified instruction/data memory between fetch (IF) and
// load/store (DM), sequencing each access through a fixed-latency memory.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);

  state_e           state;
  owner_e           owner;
  owner_e           last_owner;
  logic             we_q;
  logic [CNT_W-1:0] cnt;
  logic             arb_valid;
  logic             arb_winner;

  riscv_rr_arb2 u_arb (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  // Access sequencer; every output is registered, and strobes default low so
  // each one is a single-cycle pulse set on entry to ISSUE or RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_DM;
      we_q       <= 1'b0;
      cnt        <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (arb_valid) begin
            state <= ISSUE;
            owner <= owner_e'(arb_winner);
            if (arb_winner == OWN_DM) begin
              we_q      <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_we    <= dm_we;
              mem_re    <= ~dm_we;
              dm_gnt    <= 1'b1;
            end else begin
              we_q     <= 1'b0;
              mem_addr <= if_addr;
              mem_re   <= 1'b1;
              if_gnt   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          last_owner <= owner;
          if (we_q) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= RESP;
            if (owner == OWN_DM) begin
              dm_rdata  <= mem_rdata;
              dm_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed scenarios plus a randomized two-requester
// run, checked against a transaction-level model of the arbitration rules.
module tb_riscv_mem_arbiter;

  localparam int L    = 2;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;

  logic        b_if_req = 1'b0, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr = '0, b_if_rdata;
  logic        b_dm_req = 1'b0, b_dm_we = 1'b0, b_dm_gnt, b_dm_rvalid;
  logic [31:0] b_dm_addr = '0, b_dm_wdata = '0, b_dm_rdata;
  logic        b_mem_re, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata = '0;

  riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  riscv_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_re(b_mem_re), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] phys_mem [256];
  logic [31:0] ref_mem  [256];
  bit          pend_v   [NCYC];
  logic [31:0] pend_d   [NCYC];

  bit          e_if_gnt [NCYC];
  bit          e_dm_gnt [NCYC];
  bit          e_re     [NCYC];
  bit          e_we     [NCYC];
  bit          e_if_rv  [NCYC];
  bit          e_dm_rv  [NCYC];
  logic [31:0] e_addr   [NCYC];
  logic [31:0] e_wdata  [NCYC];
  logic [31:0] e_rdata  [NCYC];
  int          arb_from;
  bit          m_last;
  logic [31:0] m_if_rdata, m_dm_rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < NCYC; i++) begin
      e_if_gnt[i] = 0; e_dm_gnt[i] = 0; e_re[i] = 0; e_we[i] = 0;
      e_if_rv[i] = 0;  e_dm_rv[i] = 0;  pend_v[i] = 0;
      e_addr[i] = '0;  e_wdata[i] = '0; e_rdata[i] = '0;
    end
    arb_from   = 0;
    m_last     = 1'b1;
    m_if_rdata = '0;
    m_dm_rdata = '0;
  endtask

  // Transaction model: a grant follows the first sampled request once the
  // memory is free; a load occupies it until its response cycle, a store for one cycle.
  task automatic model_sample();
    bit w;
    int g;
    if (reset_n && cyc >= arb_from && (if_req || dm_req)) begin
      g = cyc + 1;
      w = (if_req && dm_req) ? !m_last : dm_req;
      if (!w) begin
        e_if_gnt[g] = 1; e_re[g] = 1; e_addr[g] = if_addr;
        e_if_rv[g+L+1] = 1; e_rdata[g+L+1] = ref_mem[if_addr[9:2]];
        arb_from = g + L + 1;
      end else if (dm_we) begin
        e_dm_gnt[g] = 1; e_we[g] = 1; e_addr[g] = dm_addr; e_wdata[g] = dm_wdata;
        ref_mem[dm_addr[9:2]] = dm_wdata;
        arb_from = g + 1;
      end else begin
        e_dm_gnt[g] = 1; e_re[g] = 1; e_addr[g] = dm_addr;
        e_dm_rv[g+L+1] = 1; e_rdata[g+L+1] = ref_mem[dm_addr[9:2]];
        arb_from = g + L + 1;
      end
      m_last = w;
    end
  endtask

  // One clock cycle: model samples inputs, memory reacts, scoreboard compares outputs.
  task automatic step();
    model_sample();
    @(posedge clk); #1; cyc++;
    if (mem_we) phys_mem[mem_addr[9:2]] = mem_wdata;
    if (mem_re && cyc + L < NCYC) begin
      pend_v[cyc+L] = 1; pend_d[cyc+L] = phys_mem[mem_addr[9:2]];
    end
    mem_rdata = pend_v[cyc] ? pend_d[cyc] : $urandom();
    if (e_if_rv[cyc]) m_if_rdata = e_rdata[cyc];
    if (e_dm_rv[cyc]) m_dm_rdata = e_rdata[cyc];
    n_checks++; if (if_gnt !== e_if_gnt[cyc]) begin n_fail++; $display("FAIL sb_if_gnt cyc %0d: got %b want %b", cyc, if_gnt, e_if_gnt[cyc]); end
    n_checks++; if (dm_gnt !== e_dm_gnt[cyc]) begin n_fail++; $display("FAIL sb_dm_gnt cyc %0d: got %b want %b", cyc, dm_gnt, e_dm_gnt[cyc]); end
    n_checks++; if (mem_re !== e_re[cyc]) begin n_fail++; $display("FAIL sb_mem_re cyc %0d: got %b want %b", cyc, mem_re, e_re[cyc]); end
    n_checks++; if (mem_we !== e_we[cyc]) begin n_fail++; $display("FAIL sb_mem_we cyc %0d: got %b want %b", cyc, mem_we, e_we[cyc]); end
    n_checks++; if (if_rvalid !== e_if_rv[cyc]) begin n_fail++; $display("FAIL sb_if_rvalid cyc %0d: got %b want %b", cyc, if_rvalid, e_if_rv[cyc]); end
    n_checks++; if (dm_rvalid !== e_dm_rv[cyc]) begin n_fail++; $display("FAIL sb_dm_rvalid cyc %0d: got %b want %b", cyc, dm_rvalid, e_dm_rv[cyc]); end
    n_checks++; if (if_rdata !== m_if_rdata) begin n_fail++; $display("FAIL sb_if_rdata cyc %0d: got %h want %h", cyc, if_rdata, m_if_rdata); end
    n_checks++; if (dm_rdata !== m_dm_rdata) begin n_fail++; $display("FAIL sb_dm_rdata cyc %0d: got %h want %h", cyc, dm_rdata, m_dm_rdata); end
    if (e_re[cyc] || e_we[cyc]) begin
      n_checks++; if (mem_addr !== e_addr[cyc]) begin n_fail++; $display("FAIL sb_mem_addr cyc %0d: got %h want %h", cyc, mem_addr, e_addr[cyc]); end
    end
    if (e_we[cyc]) begin
      n_checks++; if (mem_wdata !== e_wdata[cyc]) begin n_fail++; $display("FAIL sb_mem_wdata cyc %0d: got %h want %h", cyc, mem_wdata, e_wdata[cyc]); end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
    #1;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = $urandom();
      ref_mem[i]  = phys_mem[i];
    end
    #1 reset_n = 1'b0;
    #2;
    n_checks++; if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_re, mem_we} !== 6'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 000000", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_re, mem_we}); end
    n_checks++; if (if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
    n_checks++; if (dm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    do_reset();
  endtask

  task automatic test_if_load();
    do_reset();
    phys_mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h100;
    step();
    n_checks++; if (if_gnt !== 1'b1 || mem_re !== 1'b1) begin n_fail++; $display("FAIL if_load_issue: gnt %b re %b want 1 1", if_gnt, mem_re); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL if_load_addr: got %h want 00000100", mem_addr); end
    if_req = 0;
    step(); step();
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_load_early_rvalid: got %b want 0", if_rvalid); end
    step();
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_load_resp: rvalid %b rdata %h want 1 deadbeef", if_rvalid, if_rdata); end
    n_checks++; if (dm_gnt !== 1'b0 || dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL if_load_dm_quiet: gnt %b rvalid %b want 0 0", dm_gnt, dm_rvalid); end
    step();
    n_checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL if_load_hold: rvalid %b rdata %h want 0 deadbeef", if_rvalid, if_rdata); end
  endtask

  task automatic test_dm_store();
    do_reset();
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678;
    step();
    n_checks++; if (dm_gnt !== 1'b1 || mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL store_issue: gnt %b we %b re %b want 1 1 0", dm_gnt, mem_we, mem_re); end
    n_checks++; if (mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL store_bus: addr %h wdata %h want 00000200 12345678", mem_addr, mem_wdata); end
    dm_req = 0; dm_we = 0;
    step();
    if_req = 1; if_addr = 32'h200;
    step();
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL store_back_to_idle: if_gnt %b want 1", if_gnt); end
    if_req = 0;
    step(); step(); step();
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h12345678) begin n_fail++; $display("FAIL store_readback: rvalid %b rdata %h want 1 12345678", if_rvalid, if_rdata); end
    n_checks++; if (dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_no_rvalid: got %b want 0", dm_rvalid); end
  endtask

  task automatic test_both_loads();
    do_reset();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
    for (int c = 1; c <= 12; c++) begin
      step();
      n_checks++; if (if_gnt !== (c == 1 || c == 9)) begin n_fail++; $display("FAIL rr_if_gnt c%0d: got %b", c, if_gnt); end
      n_checks++; if (dm_gnt !== (c == 5)) begin n_fail++; $display("FAIL rr_dm_gnt c%0d: got %b", c, dm_gnt); end
      n_checks++; if (if_rvalid !== (c == 4 || c == 12)) begin n_fail++; $display("FAIL rr_if_rvalid c%0d: got %b", c, if_rvalid); end
      n_checks++; if (dm_rvalid !== (c == 8)) begin n_fail++; $display("FAIL rr_dm_rvalid c%0d: got %b", c, dm_rvalid); end
      if (c == 9) begin if_req = 0; dm_req = 0; end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1; if_addr = 32'h40;
    step();
    n_checks++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL abort_gnt: got %b want 1", if_gnt); end
    if_req = 0;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_re, mem_we} !== 6'b0) begin n_fail++; $display("FAIL abort_strobes: got %b want 000000", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_re, mem_we}); end
    n_checks++; if (mem_addr !== 32'h0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_regs: addr %h rdata %h want 0 0", mem_addr, if_rdata); end
    model_reset();
    step();
    reset_n = 1'b1;
    for (int c = 4; c <= 10; c++) begin
      step();
      n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL abort_rvalid c%0d: got %b want 0", c, if_rvalid); end
    end
  endtask

  task automatic test_continuous_if();
    logic prev_re;
    do_reset();
    prev_re = 1'b0;
    if_req = 1; if_addr = $urandom() & 32'hFFFFFC3C;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c <= 10) begin
        n_checks++; if (if_gnt !== (c == 1 || c == 5 || c == 9)) begin n_fail++; $display("FAIL cont_if_gnt c%0d: got %b", c, if_gnt); end
      end
      n_checks++; if (mem_re && prev_re) begin n_fail++; $display("FAIL cont_re_consecutive c%0d: got 1 want 0", c); end
      prev_re = mem_re;
      if (if_gnt) if_addr = $urandom() & 32'hFFFFFC3C;
    end
    if_req = 0;
    repeat (5) step();
  endtask

  task automatic test_latency_one();
    do_reset();
    b_if_req = 1; b_if_addr = 32'h40; b_mem_rdata = $urandom();
    step();
    n_checks++; if (b_if_gnt !== 1'b1 || b_mem_re !== 1'b1 || b_mem_addr !== 32'h40) begin n_fail++; $display("FAIL lat1_issue: gnt %b re %b addr %h want 1 1 00000040", b_if_gnt, b_mem_re, b_mem_addr); end
    n_checks++; if (b_dm_gnt !== 1'b0 || b_mem_we !== 1'b0) begin n_fail++; $display("FAIL lat1_dm_quiet: gnt %b we %b want 0 0", b_dm_gnt, b_mem_we); end
    b_if_req = 0; b_mem_rdata = $urandom();
    step();
    b_mem_rdata = 32'hCAFEF00D;
    n_checks++; if (b_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat1_early: rvalid %b want 0", b_if_rvalid); end
    step();
    n_checks++; if (b_if_rvalid !== 1'b1 || b_if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat1_resp: rvalid %b rdata %h want 1 cafef00d", b_if_rvalid, b_if_rdata); end
    n_checks++; if (b_dm_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat1_dm_rvalid: got %b want 0", b_dm_rvalid); end
    b_mem_rdata = $urandom();
    step();
    n_checks++; if (b_if_rvalid !== 1'b0 || b_if_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL lat1_hold: rvalid %b rdata %h want 0 cafef00d", b_if_rvalid, b_if_rdata); end
    n_checks++; if (b_dm_rdata !== 32'h0 || b_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL lat1_idle_regs: dm_rdata %h wdata %h want 0 0", b_dm_rdata, b_mem_wdata); end
  endtask

  task automatic test_back_to_back();
    bit if_busy, dm_busy;
    do_reset();
    if_busy = 0; dm_busy = 0;
    for (int c = 0; c < 1500; c++) begin
      if (if_gnt) if_busy = 0;
      if (dm_gnt) dm_busy = 0;
      if (!if_busy && $urandom_range(0, 99) < 60) begin
        if_busy = 1; if_addr = $urandom() & 32'hFFFFFC3C;
      end
      if (!dm_busy && $urandom_range(0, 99) < 60) begin
        dm_busy = 1; dm_we = $urandom_range(0, 1) == 1;
        dm_addr = $urandom() & 32'hFFFFFC3C; dm_wdata = $urandom();
      end
      if_req = if_busy;
      dm_req = dm_busy;
      step();
    end
    if_req = 0; dm_req = 0;
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_if_load();
    test_dm_store();
    test_both_loads();
    test_reset_mid();
    test_continuous_if();
    test_latency_one();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
